pio_in_debounce_edge: RTL and testbench

PIO_IN_DEBOUNCE_EDGE -- requirements
Module: pio_in_debounce_edge

---
 rtl/pio_in_debounce_edge_if.sv | 19 +
 rtl/pio_in_debounce_edge.sv | 104 ++++++++++
 tb/tb_pio_in_debounce_edge.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_in_debounce_edge_if.sv
// rtl/pio_in_debounce_edge_if.sv - register bus between a host and the debounced PIO input block.
interface pio_in_debounce_edge_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/pio_in_debounce_edge.sv
// rtl/pio_in_debounce_edge.sv - debounced parallel input port with edge capture and level interrupt.
module pio_in_debounce_edge #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b1}}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_port,
  pio_in_debounce_edge_if.slave  bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_stable;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_edge_capture;
  logic [WIDTH-1:0] r_irq_mask;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_stable_next;
  logic [CW-1:0]    w_cnt_next [WIDTH];
  logic [WIDTH-1:0] w_event;
  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd_mux;
  logic             w_unused_wdata;

  // A channel only flips after sync2 has disagreed with stable for DEBOUNCE_CYCLES clocks in a row.
  always_comb begin
    w_stable_next = r_stable;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_stable_next[i] = r_sync2[i];
        w_cnt_next[i]    = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + 1'b1;
      end
    end
  end

  assign w_event = (~r_stable &  w_stable_next & r_rise_en)
                 | ( r_stable & ~w_stable_next & r_fall_en);

  assign w_wr           = bus.chipselect & ~bus.write_n;
  assign w_wdata        = bus.writedata[WIDTH-1:0];
  assign w_w1c          = (w_wr && bus.address == 3'd3) ? w_wdata : '0;
  assign w_unused_wdata = ^bus.writedata;

  always_comb begin
    w_rd_mux = '0;
    case (bus.address)
      3'd0:    w_rd_mux = 32'(r_stable);
      3'd1:    w_rd_mux = 32'(r_sync2);
      3'd2:    w_rd_mux = 32'(r_irq_mask);
      3'd3:    w_rd_mux = 32'(r_edge_capture);
      3'd4:    w_rd_mux = 32'(r_rise_en);
      3'd5:    w_rd_mux = 32'(r_fall_en);
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1        <= RESET_VALUE;
      r_sync2        <= RESET_VALUE;
      r_stable       <= RESET_VALUE;
      r_edge_capture <= '0;
      r_irq_mask     <= '0;
      r_rise_en      <= '0;
      r_fall_en      <= '1;
      r_readdata     <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1    <= in_port;
      r_sync2    <= r_sync1;
      r_stable   <= w_stable_next;
      r_readdata <= w_rd_mux;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
      // Set is applied after the clear so a new event survives a same-cycle W1C.
      r_edge_capture <= (r_edge_capture & ~w_w1c) | w_event;
      if (w_wr && bus.address == 3'd2) r_irq_mask <= w_wdata;
      if (w_wr && bus.address == 3'd4) r_rise_en  <= w_wdata;
      if (w_wr && bus.address == 3'd5) r_fall_en  <= w_wdata;
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = |(r_edge_capture & r_irq_mask);

endmodule

// File: tb/tb_pio_in_debounce_edge.sv
// tb/tb_pio_in_debounce_edge.sv - directed bench for the debounced PIO input block.
module tb_pio_in_debounce_edge;

  logic       clk;
  logic       reset;
  logic [3:0] in_port;
  int         n_tests;
  int         n_fail;

  pio_in_debounce_edge_if bus();

  pio_in_debounce_edge #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (4'hF)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.address = a;
    @(negedge clk);
    d = bus.readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    idle(3);
    n_tests++;
    if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata got=%h exp=%h", bus.readdata, 32'h0); end
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got=%b exp=%b", bus.irq, 1'b0); end
    reset = 1'b0;
    rd(3'd0, d);
    n_tests++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL reset_stable got=%h exp=%h", d, 32'hF); end
    rd(3'd1, d);
    n_tests++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL reset_sync2 got=%h exp=%h", d, 32'hF); end
    rd(3'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask got=%h exp=%h", d, 32'h0); end
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_capture got=%h exp=%h", d, 32'h0); end
    rd(3'd4, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rise_en got=%h exp=%h", d, 32'h0); end
    rd(3'd5, d);
    n_tests++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL reset_fall_en got=%h exp=%h", d, 32'hF); end
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_6 got=%h exp=%h", d, 32'h0); end
    wr(3'd2, 32'hFFFF_FFF0);
    rd(3'd2, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL mask_upper_bits got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_latency();
    logic [31:0] d;
    logic [31:0] at6;
    logic [31:0] at7;
    @(negedge clk);
    bus.address = 3'd0;
    @(negedge clk);
    in_port = 4'hE;
    at6 = '0;
    at7 = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) at6 = bus.readdata;
      if (k == 7) at7 = bus.readdata;
    end
    n_tests++;
    if (at6 !== 32'hF) begin n_fail++; $display("FAIL latency_early got=%h exp=%h", at6, 32'hF); end
    n_tests++;
    if (at7 !== 32'hE) begin n_fail++; $display("FAIL latency_exact got=%h exp=%h", at7, 32'hE); end
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL press_capture got=%h exp=%h", d, 32'h1); end
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_masked got=%b exp=%b", bus.irq, 1'b0); end
    wr(3'd2, 32'h1);
    n_tests++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL press_irq_unmasked got=%b exp=%b", bus.irq, 1'b1); end
    in_port = 4'hF;
    idle(10);
    wr(3'd3, 32'hF);
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL release_irq_cleared got=%b exp=%b", bus.irq, 1'b0); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    @(negedge clk);
    in_port = 4'hD;
    idle(3);
    in_port = 4'hF;
    idle(10);
    rd(3'd0, d);
    n_tests++;
    if (d !== 32'hF) begin n_fail++; $display("FAIL glitch_stable got=%h exp=%h", d, 32'hF); end
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_capture got=%h exp=%h", d, 32'h0); end
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL glitch_irq got=%b exp=%b", bus.irq, 1'b0); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    @(negedge clk);
    in_port = 4'hC;
    idle(10);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL w1c_pre got=%h exp=%h", d, 32'h3); end
    n_tests++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL w1c_pre_irq got=%b exp=%b", bus.irq, 1'b1); end
    wr(3'd3, 32'h1);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL w1c_post got=%h exp=%h", d, 32'h2); end
    n_tests++;
    if (bus.irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_mask1 got=%b exp=%b", bus.irq, 1'b0); end
    wr(3'd2, 32'h2);
    n_tests++;
    if (bus.irq !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_mask2 got=%b exp=%b", bus.irq, 1'b1); end
    in_port = 4'hF;
    idle(10);
    wr(3'd2, 32'h0);
    wr(3'd3, 32'hF);
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    @(negedge clk);
    in_port = 4'hE;
    idle(10);
    wr(3'd4, 32'h1);
    @(negedge clk);
    in_port = 4'hF;
    idle(5);
    bus.address    = 3'd3;
    bus.writedata  = 32'h1;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL w1c_collision got=%h exp=%h", d, 32'h1); end
    wr(3'd3, 32'hF);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_after_collision got=%h exp=%h", d, 32'h0); end
    wr(3'd4, 32'h0);
  endtask

  task automatic test_rise_only();
    logic [31:0] d;
    wr(3'd4, 32'h8);
    wr(3'd5, 32'h0);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL enable_change_no_event got=%h exp=%h", d, 32'h0); end
    @(negedge clk);
    in_port = 4'h7;
    idle(10);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rise_only_fall got=%h exp=%h", d, 32'h0); end
    in_port = 4'hF;
    idle(10);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL rise_only_rise got=%h exp=%h", d, 32'h8); end
    wr(3'd4, 32'h0);
    wr(3'd5, 32'hF);
    rd(3'd3, d);
    n_tests++;
    if (d !== 32'h8) begin n_fail++; $display("FAIL enable_change_keeps got=%h exp=%h", d, 32'h8); end
    wr(3'd3, 32'hF);
  endtask

  task automatic test_reset_mid();
    logic [31:0] at6;
    logic [31:0] at7;
    logic [31:0] d;
    @(negedge clk);
    in_port = 4'h7;
    idle(2);
    reset       = 1'b1;
    bus.address = 3'd3;
    @(negedge clk);
    reset = 1'b0;
    at6 = '0;
    at7 = '0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 6) at6 = bus.readdata;
      if (k == 7) at7 = bus.readdata;
    end
    n_tests++;
    if (at6 !== 32'h0) begin n_fail++; $display("FAIL reset_mid_no_event got=%h exp=%h", at6, 32'h0); end
    n_tests++;
    if (at7 !== 32'h8) begin n_fail++; $display("FAIL reset_mid_event got=%h exp=%h", at7, 32'h8); end
    rd(3'd0, d);
    n_tests++;
    if (d !== 32'h7) begin n_fail++; $display("FAIL reset_mid_stable got=%h exp=%h", d, 32'h7); end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b1;
    in_port        = 4'hF;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'h0;
    test_reset();
    test_unmapped();
    test_latency();
    test_glitch();
    test_w1c();
    test_w1c_collision();
    test_rise_only();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
